npem_command_controller: RTL and testbench

Sequences Native PCIe Enclosure Management (NPEM) commands between the configuration-space NPEM Control/Status registers and the enclosure-side indicator interface. It holds the NPEM Control register and forwards each software write to the enclosure over a valid/ready handshake. It waits for enclosure completion, with a timeout, and then sets NPEM Command Completed in the NPEM Status register. It sits behind the NPEM extended capability header in the function's extended config space.

---
 rtl/npem_command_controller.sv | 173 +++++++++++++++++
 tb/tb_npem_command_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/npem_command_controller.sv
// npem_command_controller: holds the NPEM Control register, forwards each enabled
// software write to the enclosure over a valid/ready handshake, waits for the
// enclosure to finish (with a timeout) and then sets NPEM Command Completed.
// Optional feature macro: NPEM_CC_IRQ_EN adds cc_int_en / cc_irq (Command
// Completed interrupt pulse). The default build has neither port.
module npem_command_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CMD_WIDTH      = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ctrl_wr_valid,
  input  logic [31:0]          ctrl_wr_data,
  output logic [31:0]          ctrl_reg,
  input  logic                 status_wr_valid,
  input  logic [31:0]          status_wr_data,
  output logic [31:0]          status_reg,
  output logic                 enc_req_valid,
  output logic [CMD_WIDTH-1:0] enc_req_data,
  input  logic                 enc_req_ready,
  input  logic                 enc_done,
  output logic                 enc_reset,
  output logic                 busy,
`ifdef NPEM_CC_IRQ_EN
  input  logic                 cc_int_en,
  output logic                 cc_irq,
`endif
  output logic                 timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // Writable Control bits: Enable, the command field above Initiate Reset, and [31:24].
  function automatic logic [31:0] build_ctrl_mask();
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 32; i++) begin
      if (i == 0 || (i >= 2 && i < int'(CMD_WIDTH)) || i >= 24) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [31:0] CTRL_MASK = build_ctrl_mask();

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_CMPL  = 2'd3
  } state_t;

  state_t               state;
  logic                 pending;
  logic                 cc;
  logic [CNT_W-1:0]     cnt;

  logic [31:0]          wr_val_c;
  logic                 rst_cmd_c;
  logic                 go_cmd_c;
  logic                 pend_next_c;
  logic                 timeout_c;
  logic                 handshake_c;
  logic [CMD_WIDTH-1:0] cmd_next_c;
  logic                 unused_status_bits;

  // Decode of the current config write and the in-flight command conditions.
  always_comb begin
    wr_val_c    = ctrl_wr_data & CTRL_MASK;
    rst_cmd_c   = ctrl_wr_valid & ctrl_wr_data[1];
    go_cmd_c    = ctrl_wr_valid & ctrl_wr_data[0] & ~ctrl_wr_data[1];
    pend_next_c = ctrl_wr_valid ? go_cmd_c : pending;
    timeout_c   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    handshake_c = enc_req_valid & enc_req_ready;
    // Latest Control value; Initiate Reset is never stored so bit 1 is already 0.
    cmd_next_c  = ctrl_wr_valid ? wr_val_c[CMD_WIDTH-1:0] : ctrl_reg[CMD_WIDTH-1:0];
  end

  assign status_reg         = {31'b0, cc};
  assign unused_status_bits = ^status_wr_data[31:1];

  // Command sequencer, Control/Status registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pending       <= 1'b0;
      cc            <= 1'b0;
      cnt           <= '0;
      ctrl_reg      <= 32'h0;
      enc_req_valid <= 1'b0;
      enc_req_data  <= '0;
      enc_reset     <= 1'b0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
`ifdef NPEM_CC_IRQ_EN
      cc_irq        <= 1'b0;
`endif
    end else begin
      enc_reset   <= rst_cmd_c;
      timeout_err <= 1'b0;
`ifdef NPEM_CC_IRQ_EN
      cc_irq      <= 1'b0;
`endif
      if (ctrl_wr_valid) ctrl_reg <= wr_val_c;
      // W1C first so a completion set later in this block takes priority.
      if (status_wr_valid && status_wr_data[0]) cc <= 1'b0;

      if (rst_cmd_c) begin
        state         <= S_IDLE;
        enc_req_valid <= 1'b0;
        pending       <= 1'b0;
        busy          <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (go_cmd_c) begin
              state         <= S_ISSUE;
              enc_req_valid <= 1'b1;
              enc_req_data  <= cmd_next_c;
              cnt           <= '0;
              busy          <= 1'b1;
            end else begin
              busy <= 1'b0;
            end
          end
          S_ISSUE: begin
            pending <= pend_next_c;
            cnt     <= cnt + CNT_W'(1);
            if (timeout_c) begin
              state         <= S_CMPL;
              enc_req_valid <= 1'b0;
              timeout_err   <= 1'b1;
            end else if (handshake_c) begin
              state         <= S_WAIT;
              enc_req_valid <= 1'b0;
            end
          end
          S_WAIT: begin
            pending <= pend_next_c;
            cnt     <= cnt + CNT_W'(1);
            if (timeout_c) begin
              state       <= S_CMPL;
              timeout_err <= 1'b1;
            end else if (enc_done) begin
              state <= S_CMPL;
            end
          end
          S_CMPL: begin
            cc <= 1'b1;
`ifdef NPEM_CC_IRQ_EN
            cc_irq <= cc_int_en & ~cc;
`endif
            pending <= 1'b0;
            if (pend_next_c) begin
              state         <= S_ISSUE;
              enc_req_valid <= 1'b1;
              enc_req_data  <= cmd_next_c;
              cnt           <= '0;
              busy          <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_npem_command_controller.sv
// Bench for npem_command_controller: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_npem_command_controller;

  localparam int unsigned TO = 8;
  localparam int unsigned CW = 12;
  localparam logic [31:0] CTRL_MASK = 32'hFF00_0FFD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ctrl_wr_valid;
  logic [31:0]   ctrl_wr_data;
  logic [31:0]   ctrl_reg;
  logic          status_wr_valid;
  logic [31:0]   status_wr_data;
  logic [31:0]   status_reg;
  logic          enc_req_valid;
  logic [CW-1:0] enc_req_data;
  logic          enc_req_ready;
  logic          enc_done;
  logic          enc_reset;
  logic          busy;
  logic          timeout_err;
  logic          cc_int_en;
`ifdef NPEM_CC_IRQ_EN
  logic          cc_irq;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one outstanding command described by its progress.
  logic [31:0]   m_ctrl;
  logic          m_cc;
  logic          m_valid;
  logic [CW-1:0] m_data;
  logic          m_rst_pulse;
  logic          m_to_pulse;
  logic          m_irq;
  bit            m_active;
  bit            m_accepted;
  int            m_age;
  bit            m_closing;
  bit            m_queued;

  npem_command_controller #(.TIMEOUT_CYCLES(TO), .CMD_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_wr_valid(ctrl_wr_valid), .ctrl_wr_data(ctrl_wr_data), .ctrl_reg(ctrl_reg),
    .status_wr_valid(status_wr_valid), .status_wr_data(status_wr_data), .status_reg(status_reg),
    .enc_req_valid(enc_req_valid), .enc_req_data(enc_req_data), .enc_req_ready(enc_req_ready),
    .enc_done(enc_done), .enc_reset(enc_reset), .busy(busy),
`ifdef NPEM_CC_IRQ_EN
    .cc_int_en(cc_int_en), .cc_irq(cc_irq),
`endif
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 32'h0; m_cc = 1'b0; m_valid = 1'b0; m_data = '0;
    m_rst_pulse = 1'b0; m_to_pulse = 1'b0; m_irq = 1'b0;
    m_active = 1'b0; m_accepted = 1'b0; m_age = 0; m_closing = 1'b0; m_queued = 1'b0;
  endtask

  task automatic launch();
    m_active = 1'b1; m_accepted = 1'b0; m_age = 0;
    m_valid = 1'b1; m_data = m_ctrl[CW-1:0];
  endtask

  // Advance the model by one clock using the inputs the DUT sampled.
  task automatic model_update();
    bit wr_rst, go, old_cc, q;
    wr_rst = ctrl_wr_valid && ctrl_wr_data[1];
    go     = ctrl_wr_valid && ctrl_wr_data[0] && !ctrl_wr_data[1];
    old_cc = m_cc;
    m_rst_pulse = wr_rst; m_to_pulse = 1'b0; m_irq = 1'b0;
    if (status_wr_valid && status_wr_data[0]) m_cc = 1'b0;
    if (ctrl_wr_valid) m_ctrl = ctrl_wr_data & CTRL_MASK;
    if (wr_rst) begin
      m_active = 1'b0; m_closing = 1'b0; m_queued = 1'b0; m_valid = 1'b0;
    end else if (m_closing) begin
      m_cc = 1'b1;
      m_irq = cc_int_en && !old_cc;
      m_closing = 1'b0;
      q = ctrl_wr_valid ? go : m_queued;
      m_queued = 1'b0;
      if (q) launch();
    end else if (m_active) begin
      if (ctrl_wr_valid) m_queued = go;
      if (m_age + 1 == int'(TO)) begin
        m_active = 1'b0; m_valid = 1'b0; m_to_pulse = 1'b1; m_closing = 1'b1;
      end else if (!m_accepted && enc_req_ready) begin
        m_accepted = 1'b1; m_valid = 1'b0;
      end else if (m_accepted && enc_done) begin
        m_active = 1'b0; m_closing = 1'b1;
      end
      m_age++;
    end else if (go) begin
      launch();
    end
  endtask

  task automatic check_all();
    check("ctrl_reg", ctrl_reg, m_ctrl);
    check("status_reg", status_reg, {31'b0, m_cc});
    check("enc_req_valid", 32'(enc_req_valid), 32'(m_valid));
    check("enc_req_data", 32'(enc_req_data), 32'(m_data));
    check("enc_reset", 32'(enc_reset), 32'(m_rst_pulse));
    check("busy", 32'(busy), 32'(m_active || m_closing || m_queued));
    check("timeout_err", 32'(timeout_err), 32'(m_to_pulse));
`ifdef NPEM_CC_IRQ_EN
    check("cc_irq", 32'(cc_irq), 32'(m_irq));
`endif
  endtask

  // Apply one cycle of inputs (called at a negedge), clock it, then compare.
  task automatic cyc(input bit wv, input logic [31:0] wd, input bit sv, input logic [31:0] sd,
                     input bit rdy, input bit done);
    ctrl_wr_valid = wv; ctrl_wr_data = wd;
    status_wr_valid = sv; status_wr_data = sd;
    enc_req_ready = rdy; enc_done = done;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    ctrl_wr_valid = 1'b0; ctrl_wr_data = 32'h0;
    status_wr_valid = 1'b0; status_wr_data = 32'h0;
    enc_req_ready = 1'b0; enc_done = 1'b0; cc_int_en = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Basic command with completion, then W1C of Command Completed.
    cyc(1'b1, 32'h0000_0011, 1'b0, 32'h0, 1'b1, 1'b0);
    check("first_cmd_data", 32'(enc_req_data), 32'h011);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle(2);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(3);
    check("cc_after_cmd", status_reg, 32'h1);
    cyc(1'b0, 32'h0, 1'b1, 32'h1, 1'b0, 1'b0);
    check("cc_w1c", status_reg, 32'h0);

    // Timeout with ready held low.
    cyc(1'b1, 32'h0000_0001, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(int'(TO) + 3);
    check("cc_after_timeout", status_reg, 32'h1);

    // Writes while busy: only the latest is reissued.
    cyc(1'b1, 32'h0000_0005, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'h0000_0009, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0021, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(1);
    check("reissue_valid", 32'(enc_req_valid), 32'h1);
    check("reissue_data", 32'(enc_req_data), 32'h021);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(3);

    // Initiate Reset while waiting; a later enc_done is ignored.
    cyc(1'b0, 32'h0, 1'b1, 32'h1, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0005, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'h0000_0003, 1'b0, 32'h0, 1'b0, 1'b0);
    check("reset_pulse", 32'(enc_reset), 32'h1);
    check("reset_ctrl", ctrl_reg, 32'h1);
    check("reset_busy", 32'(busy), 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(2);
    check("reset_no_cc", status_reg, 32'h0);

    // W1C in the same cycle Command Completed is set: set wins.
    cyc(1'b1, 32'h0000_0101, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 32'h1, 1'b0, 1'b0);
    check("set_wins", status_reg, 32'h1);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] wd, sd;
      bit wv, sv, rdy, done;
      wv = ($urandom % 8) == 0;
      wd = $urandom;
      if (($urandom % 6) != 0) wd[1] = 1'b0;
      if (($urandom % 4) != 0) wd[0] = 1'b1;
      sv = ($urandom % 10) == 0;
      sd = $urandom;
      rdy = ($urandom % 3) == 0;
      done = ($urandom % 4) == 0;
      cc_int_en = 1'($urandom % 2);
      cyc(wv, wd, sv, sd, rdy, done);
      if (i == 1000) begin
        // Asynchronous reset between clock edges.
        #3 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
